rx_sample_buffer: RTL and testbench



---
 rtl/rx_sample_buffer_if.sv | 47 ++++
 rtl/rx_sample_buffer.sv | 186 ++++++++++++++++++
 tb/tb_rx_sample_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_sample_buffer_if.sv
// rx_sample_buffer_if
//   Bundles the sample-input strobe, the CPU-side word reader and the
//   status flags of the RX sample buffer into one interface.
//
//   Producer side (CIC + CPU reader) -> buffer:
//     in_strobe     one-cycle pulse, in_i/in_q valid
//     in_i, in_q    signed I/Q samples, IN_WIDTH bits
//     rd_word       one-cycle pulse, current dout consumed
//     clr_overflow  one-cycle pulse, clears the sticky overflow flag
//   Buffer -> reader:
//     dout          current 16-bit output word
//     word_phase    0 = I low, 1 = Q low, 2 = packed MSBs
//     count         samples held, including the one being read
//     empty         count == 0
//     block_ready   count >= BLOCK_SAMPS
//     overflow      sticky, a sample was dropped while full
//
//   Modports: master = the side that drives samples and reads words,
//             slave  = the buffer itself.
interface rx_sample_buffer_if #(
  parameter int IN_WIDTH = 24,
  parameter int DEPTH    = 512
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                        in_strobe;
  logic signed [IN_WIDTH-1:0]  in_i;
  logic signed [IN_WIDTH-1:0]  in_q;
  logic                        rd_word;
  logic                        clr_overflow;
  logic [15:0]                 dout;
  logic [1:0]                  word_phase;
  logic [CNT_W-1:0]            count;
  logic                        empty;
  logic                        block_ready;
  logic                        overflow;

  modport master (
    output in_strobe, in_i, in_q, rd_word, clr_overflow,
    input  dout, word_phase, count, empty, block_ready, overflow
  );

  modport slave (
    input  in_strobe, in_i, in_q, rd_word, clr_overflow,
    output dout, word_phase, count, empty, block_ready, overflow
  );
endinterface

// File: rtl/rx_sample_buffer.sv
// rx_sample_buffer
//   Captures one I/Q pair per decimated strobe from the second CIC stage
//   into a DEPTH-entry FIFO and hands each pair to the CPU reader as three
//   16-bit words: I[15:0], Q[15:0], {I[MSB-:8], Q[MSB-:8]}.
//
//   Ports:
//     clock  sample-domain clock (same as the CIC chain)
//     reset  asynchronous, active-high; clears all control state at once
//     bus    rx_sample_buffer_if.slave (strobe/samples in, words and
//            status flags out)
//
//   count is the only full/empty authority; read/write pointers are free
//   running modulo DEPTH and are never compared on their own.
module rx_sample_buffer #(
  parameter int IN_WIDTH    = 24,
  parameter int DEPTH       = 512,
  parameter int BLOCK_SAMPS = 170
) (
  input  logic             clock,
  input  logic             reset,
  rx_sample_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * IN_WIDTH;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BLK_C   = CW'(BLOCK_SAMPS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PONE_C  = AW'(1);

  typedef enum logic [1:0] {
    PH_I_LO = 2'd0,
    PH_Q_LO = 2'd1,
    PH_MSB  = 2'd2
  } phase_t;

  // Packs an I/Q pair into one storage entry, I in the upper half.
  function automatic logic [EW-1:0] pack_entry(
    input logic signed [IN_WIDTH-1:0] si,
    input logic signed [IN_WIDTH-1:0] sq
  );
    pack_entry = {si, sq};
  endfunction

  // Selects the 16-bit word of a stored entry for the given read phase.
  function automatic logic [15:0] word_of(
    input logic [EW-1:0] e,
    input phase_t        ph
  );
    logic signed [IN_WIDTH-1:0] si;
    logic signed [IN_WIDTH-1:0] sq;
    si = e[EW-1 -: IN_WIDTH];
    sq = e[IN_WIDTH-1:0];
    case (ph)
      PH_I_LO: word_of = si[15:0];
      PH_Q_LO: word_of = sq[15:0];
      PH_MSB:  word_of = {si[IN_WIDTH-1 -: 8], sq[IN_WIDTH-1 -: 8]};
      default: word_of = 16'h0000;
    endcase
  endfunction

  // Control state
  phase_t          phase_q;
  phase_t          phase_d;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   rd_ptr_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            empty_q;
  logic            block_ready_q;
  logic            overflow_q;

  // Per-cycle decisions
  logic            full_p0;
  logic            adv_p0;
  logic            pop_p0;
  logic            wr_p0;
  logic            drop_p0;
  logic [EW-1:0]   wdata_p0;

  // Storage and prefetched head entry
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head_p1;

  // ---- stage p0: decode strobe / read pulse against current count ----
  always_comb begin
    full_p0  = (count_q == DEPTH_C);
    adv_p0   = bus.rd_word && !empty_q;
    pop_p0   = adv_p0 && (phase_q == PH_MSB);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_p0    = bus.in_strobe && (!full_p0 || pop_p0);
    drop_p0  = bus.in_strobe && full_p0 && !pop_p0;
    wdata_p0 = pack_entry(bus.in_i, bus.in_q);

    count_d = count_q;
    if (wr_p0 && !pop_p0) begin
      count_d = count_q + ONE_C;
    end else if (pop_p0 && !wr_p0) begin
      count_d = count_q - ONE_C;
    end

    rd_ptr_d = pop_p0 ? (rd_ptr_q + PONE_C) : rd_ptr_q;
  end

  // Word-phase FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= PH_I_LO;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Word-phase FSM: next state (advances only on a non-ignored rd_word)
  always_comb begin
    phase_d = phase_q;
    if (adv_p0) begin
      case (phase_q)
        PH_I_LO: phase_d = PH_Q_LO;
        PH_Q_LO: phase_d = PH_MSB;
        PH_MSB:  phase_d = PH_I_LO;
        default: phase_d = PH_I_LO;
      endcase
    end
  end

  // Word-phase FSM: outputs. dout is forced to zero while empty, which also
  // hides the unreset head register after reset.
  always_comb begin
    bus.word_phase = phase_q;
    bus.dout       = 16'h0000;
    if (!empty_q) begin
      bus.dout = word_of(head_p1, phase_q);
    end
  end

  // ---- stage p1: pointer, count and flag registers ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      block_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (wr_p0) begin
        wr_ptr_q <= wr_ptr_q + PONE_C;
      end
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      // Flags follow next-state count so they line up with count itself.
      empty_q       <= (count_d == '0);
      block_ready_q <= (count_d >= BLK_C);
      if (drop_p0) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // ---- stage p1: sample storage and head prefetch (data, no reset) ----
  always_ff @(posedge clock) begin
    if (wr_p0) begin
      mem[wr_ptr_q] <= wdata_p0;
    end
    // The written entry becomes the head only when it lands at the next read
    // position, i.e. the FIFO holds just this sample afterwards; bypass the
    // memory so dout is valid in the cycle right after the write.
    if (wr_p0 && (wr_ptr_q == rd_ptr_d)) begin
      head_p1 <= wdata_p0;
    end else begin
      head_p1 <= mem[rd_ptr_d];
    end
  end

  assign bus.count       = count_q;
  assign bus.empty       = empty_q;
  assign bus.block_ready = block_ready_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_rx_sample_buffer.sv
// tb_rx_sample_buffer
//   Directed bench for rx_sample_buffer with hand-computed expected words.
module tb_rx_sample_buffer;

  localparam int IN_WIDTH    = 24;
  localparam int DEPTH       = 512;
  localparam int BLOCK_SAMPS = 170;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  rx_sample_buffer_if #(.IN_WIDTH(IN_WIDTH), .DEPTH(DEPTH)) bus ();

  rx_sample_buffer #(
    .IN_WIDTH   (IN_WIDTH),
    .DEPTH      (DEPTH),
    .BLOCK_SAMPS(BLOCK_SAMPS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_samp(input logic [23:0] si, input logic [23:0] sq);
    bus.in_strobe = 1'b1;
    bus.in_i      = si;
    bus.in_q      = sq;
    tick();
    bus.in_strobe = 1'b0;
  endtask

  task automatic rd_pulse();
    bus.rd_word = 1'b1;
    tick();
    bus.rd_word = 1'b0;
  endtask

  // Reads one whole sample, checking each of its three words first.
  task automatic rd_samp_chk(input string tag, input logic [23:0] si, input logic [23:0] sq);
    chk({tag, "_ilo"}, 64'(bus.dout), 64'(si[15:0]));
    rd_pulse();
    chk({tag, "_qlo"}, 64'(bus.dout), 64'(sq[15:0]));
    rd_pulse();
    chk({tag, "_msb"}, 64'(bus.dout), 64'({si[23:16], sq[23:16]}));
    rd_pulse();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 64'(bus.count), 64'd0);
    chk({tag, "_empty"}, 64'(bus.empty), 64'd1);
    chk({tag, "_blkrdy"}, 64'(bus.block_ready), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
    chk({tag, "_dout"}, 64'(bus.dout), 64'd0);
    chk({tag, "_phase"}, 64'(bus.word_phase), 64'd0);
  endtask

  function automatic logic [23:0] samp_i(input int k);
    samp_i = 24'(k * 32'h0001_0203 + 32'h0000_8000);
  endfunction

  function automatic logic [23:0] samp_q(input int k);
    samp_q = 24'(k * 32'h0003_0507) ^ 24'hF0F0F0;
  endfunction

  initial begin
    bus.in_strobe    = 1'b0;
    bus.in_i         = '0;
    bus.in_q         = '0;
    bus.rd_word      = 1'b0;
    bus.clr_overflow = 1'b0;
    reset            = 1'b1;
    repeat (3) tick();
    chk_reset_state("rst");
    reset = 1'b0;
    tick();

    // Basic word mapping of one sample
    wr_samp(24'h123456, 24'hABCDEF);
    chk("t1_count1", 64'(bus.count), 64'd1);
    chk("t1_w0", 64'(bus.dout), 64'h3456);
    rd_pulse();
    chk("t1_w1", 64'(bus.dout), 64'hCDEF);
    chk("t1_ph1", 64'(bus.word_phase), 64'd1);
    rd_pulse();
    chk("t1_w2", 64'(bus.dout), 64'h12AB);
    chk("t1_ph2", 64'(bus.word_phase), 64'd2);
    chk("t1_count_mid", 64'(bus.count), 64'd1);
    rd_pulse();
    chk("t1_count0", 64'(bus.count), 64'd0);
    chk("t1_empty", 64'(bus.empty), 64'd1);
    chk("t1_dout0", 64'(bus.dout), 64'd0);

    // block_ready threshold
    for (int k = 0; k < BLOCK_SAMPS - 1; k++) wr_samp(samp_i(k), samp_q(k));
    chk("t4_cnt169", 64'(bus.count), 64'd169);
    chk("t4_br169", 64'(bus.block_ready), 64'd0);
    wr_samp(samp_i(BLOCK_SAMPS - 1), samp_q(BLOCK_SAMPS - 1));
    chk("t4_cnt170", 64'(bus.count), 64'd170);
    chk("t4_br170", 64'(bus.block_ready), 64'd1);
    rd_samp_chk("t4_s0", samp_i(0), samp_q(0));
    chk("t4_cnt_after", 64'(bus.count), 64'd169);
    chk("t4_br_after", 64'(bus.block_ready), 64'd0);
    for (int k = 1; k < BLOCK_SAMPS; k++) rd_samp_chk("t4_drain", samp_i(k), samp_q(k));
    chk("t4_empty", 64'(bus.empty), 64'd1);

    // Fill to full, then overflow
    for (int k = 0; k < DEPTH; k++) wr_samp(samp_i(k), samp_q(k));
    chk("t2_full_cnt", 64'(bus.count), 64'd512);
    chk("t2_full_ovf", 64'(bus.overflow), 64'd0);
    chk("t2_full_br", 64'(bus.block_ready), 64'd1);
    wr_samp(24'hAAAAAA, 24'h555555);
    chk("t2_drop_cnt", 64'(bus.count), 64'd512);
    chk("t2_drop_ovf", 64'(bus.overflow), 64'd1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    chk("t2_clr_ovf", 64'(bus.overflow), 64'd0);
    // Clear and drop together: the drop wins
    bus.clr_overflow = 1'b1;
    wr_samp(24'h111111, 24'h222222);
    bus.clr_overflow = 1'b0;
    chk("t2_clr_drop_ovf", 64'(bus.overflow), 64'd1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    chk("t2_clr2_ovf", 64'(bus.overflow), 64'd0);

    // Write together with the phase-2 pop while full
    rd_pulse();
    rd_pulse();
    chk("t3_ph2", 64'(bus.word_phase), 64'd2);
    bus.rd_word   = 1'b1;
    bus.in_strobe = 1'b1;
    bus.in_i      = 24'h777777;
    bus.in_q      = 24'h888888;
    tick();
    bus.rd_word   = 1'b0;
    bus.in_strobe = 1'b0;
    chk("t3_cnt", 64'(bus.count), 64'd512);
    chk("t3_ovf", 64'(bus.overflow), 64'd0);
    chk("t3_ph0", 64'(bus.word_phase), 64'd0);
    for (int k = 1; k < DEPTH; k++) rd_samp_chk("t3_drain", samp_i(k), samp_q(k));
    chk("t3_last_cnt", 64'(bus.count), 64'd1);
    rd_samp_chk("t3_last", 24'h777777, 24'h888888);
    chk("t3_empty", 64'(bus.empty), 64'd1);
    chk("t3_cnt0", 64'(bus.count), 64'd0);

    // Reads while empty are ignored
    repeat (3) rd_pulse();
    chk("t5_dout", 64'(bus.dout), 64'd0);
    chk("t5_ph", 64'(bus.word_phase), 64'd0);
    chk("t5_cnt", 64'(bus.count), 64'd0);
    chk("t5_empty", 64'(bus.empty), 64'd1);
    wr_samp(24'h5ABEEF, 24'h012345);
    chk("t5_wr_dout", 64'(bus.dout), 64'hBEEF);
    chk("t5_wr_cnt", 64'(bus.count), 64'd1);

    // Asynchronous reset in the middle of a read
    wr_samp(samp_i(1), samp_q(1));
    wr_samp(samp_i(2), samp_q(2));
    chk("t6_cnt3", 64'(bus.count), 64'd3);
    repeat (4) rd_pulse();
    chk("t6_ph1", 64'(bus.word_phase), 64'd1);
    chk("t6_cnt_mid", 64'(bus.count), 64'd2);
    chk("t6_dout_mid", 64'(bus.dout), 64'(samp_q(1) & 24'h00FFFF));
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("t6_async");
    tick();
    reset = 1'b0;
    tick();
    wr_samp(24'hFFFFFF, 24'h000001);
    chk("t6_w0", 64'(bus.dout), 64'hFFFF);
    rd_pulse();
    chk("t6_w1", 64'(bus.dout), 64'h0001);
    rd_pulse();
    chk("t6_w2", 64'(bus.dout), 64'hFF00);
    rd_pulse();
    chk("t6_empty", 64'(bus.empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
